// File: rtl/set_mode_if.sv
// Button/tick inputs and display/strobe outputs of the set/mode controller.
// Pure wiring: no storage, so it adds no latency.
// No backpressure: every pulse is a one-cycle event that is acted on or dropped.
interface set_mode_if;
    logic       set_pulse;
    logic       mode_pulse;
    logic       up_pulse;
    logic       down_pulse;
    logic       tick_1hz;
    logic       alarm_match;
    logic [1:0] disp_sel;
    logic [1:0] field_sel;
    logic       edit_up;
    logic       edit_down;
    logic       load_time;
    logic       load_alarm;
    logic       alarm_en;
    logic       ringing;

    // Stimulus side: drives buttons/tick/match, observes controller outputs.
    modport master (
        output set_pulse, mode_pulse, up_pulse, down_pulse, tick_1hz, alarm_match,
        input  disp_sel, field_sel, edit_up, edit_down, load_time, load_alarm,
               alarm_en, ringing
    );

    // Controller side.
    modport slave (
        input  set_pulse, mode_pulse, up_pulse, down_pulse, tick_1hz, alarm_match,
        output disp_sel, field_sel, edit_up, edit_down, load_time, load_alarm,
               alarm_en, ringing
    );
endinterface

// File: rtl/set_mode_controller.sv
// Clock/alarm setting FSM: edit sessions, idle timeout, alarm ring control.
// Latency: every output is registered and reflects an input one clk later.
// Backpressure: none; simultaneous buttons resolve mode > set > up > down.
module set_mode_controller #(
    parameter int unsigned TIMEOUT_S = 30,
    parameter int unsigned RING_S    = 60
) (
    input  logic         clk,
    input  logic         reset,
    set_mode_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        T_AMPM = 3'd3,
        A_HOUR = 3'd4,
        A_MIN  = 3'd5,
        A_AMPM = 3'd6,
        RING   = 3'd7
    } state_t;

    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT_S);
    localparam logic [5:0] RING_C    = 6'(RING_S);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       match_q;
    logic       alarm_en_q, alarm_en_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic [1:0] field_sel_q, field_sel_d;
    logic       edit_up_q, edit_up_d;
    logic       edit_down_q, edit_down_d;
    logic       load_time_q, load_time_d;
    logic       load_alarm_q, load_alarm_d;
    logic       ringing_q, ringing_d;

    logic       any_btn, win_set, win_up, win_down;
    logic       match_rise, tick_hit, in_edit;
    logic [5:0] cnt_inc;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alarm_en_d   = alarm_en_q;
        load_time_d  = 1'b0;
        load_alarm_d = 1'b0;
        edit_up_d    = 1'b0;
        edit_down_d  = 1'b0;

        any_btn    = bus.set_pulse | bus.mode_pulse | bus.up_pulse | bus.down_pulse;
        win_set    = bus.set_pulse & ~bus.mode_pulse;
        win_up     = bus.up_pulse & ~bus.mode_pulse & ~bus.set_pulse;
        win_down   = bus.down_pulse & ~bus.mode_pulse & ~bus.set_pulse & ~bus.up_pulse;
        match_rise = bus.alarm_match & ~match_q;
        // A button in the same cycle as a tick wins: the tick is not counted.
        tick_hit   = bus.tick_1hz & ~any_btn;
        cnt_inc    = cnt_q + 6'd1;
        in_edit    = (state_q != IDLE) && (state_q != RING);

        case (state_q)
            IDLE: begin
                // Buttons take precedence over a coincident alarm edge.
                if (bus.mode_pulse)      state_d = A_HOUR;
                else if (win_set)        state_d = T_HOUR;
                else if (win_up)         alarm_en_d = ~alarm_en_q;
                else if (!any_btn && match_rise && alarm_en_q) state_d = RING;
            end
            RING: begin
                if (any_btn)                          state_d = IDLE;
                else if (tick_hit && cnt_inc == RING_C) state_d = IDLE;
            end
            default: begin
                edit_up_d   = win_up;
                edit_down_d = win_down;
                if (bus.mode_pulse) begin
                    state_d = IDLE;
                end else if (win_set) begin
                    case (state_q)
                        T_HOUR:  state_d = T_MIN;
                        T_MIN:   state_d = T_AMPM;
                        T_AMPM: begin
                            state_d     = IDLE;
                            load_time_d = 1'b1;
                        end
                        A_HOUR:  state_d = A_MIN;
                        A_MIN:   state_d = A_AMPM;
                        default: begin
                            state_d      = IDLE;
                            load_alarm_d = 1'b1;
                            alarm_en_d   = 1'b1;
                        end
                    endcase
                end else if (tick_hit && cnt_inc == TIMEOUT_C) begin
                    state_d = IDLE;
                end
            end
        endcase

        // One counter serves both the edit timeout and the ring duration.
        if (state_d != state_q || any_btn)
            cnt_d = 6'd0;
        else if (bus.tick_1hz && (in_edit || state_q == RING))
            cnt_d = cnt_inc;

        case (state_d)
            IDLE:                   disp_sel_d = 2'd0;
            T_HOUR, T_MIN, T_AMPM:  disp_sel_d = 2'd1;
            A_HOUR, A_MIN, A_AMPM:  disp_sel_d = 2'd2;
            default:                disp_sel_d = 2'd3;
        endcase
        case (state_d)
            T_HOUR, A_HOUR: field_sel_d = 2'd1;
            T_MIN,  A_MIN:  field_sel_d = 2'd2;
            T_AMPM, A_AMPM: field_sel_d = 2'd3;
            default:        field_sel_d = 2'd0;
        endcase
        ringing_d = (state_d == RING);
    end

    // State, counter, edge detector and all outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 6'd0;
            match_q      <= 1'b0;
            alarm_en_q   <= 1'b0;
            disp_sel_q   <= 2'd0;
            field_sel_q  <= 2'd0;
            edit_up_q    <= 1'b0;
            edit_down_q  <= 1'b0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            ringing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= bus.alarm_match;
            alarm_en_q   <= alarm_en_d;
            disp_sel_q   <= disp_sel_d;
            field_sel_q  <= field_sel_d;
            edit_up_q    <= edit_up_d;
            edit_down_q  <= edit_down_d;
            load_time_q  <= load_time_d;
            load_alarm_q <= load_alarm_d;
            ringing_q    <= ringing_d;
        end
    end

    assign bus.disp_sel   = disp_sel_q;
    assign bus.field_sel  = field_sel_q;
    assign bus.edit_up    = edit_up_q;
    assign bus.edit_down  = edit_down_q;
    assign bus.load_time  = load_time_q;
    assign bus.load_alarm = load_alarm_q;
    assign bus.alarm_en   = alarm_en_q;
    assign bus.ringing    = ringing_q;
endmodule

// File: tb/tb_set_mode_controller.sv
// Directed bench for set_mode_controller with default parameters.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Strobe pulses are also tallied on every falling edge to count exact occurrences.
module tb_set_mode_controller;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   up_cnt, down_cnt, lt_cnt, la_cnt;

    set_mode_if u_if ();

    set_mode_controller #(.TIMEOUT_S(30), .RING_S(60)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.edit_up    === 1'b1) up_cnt++;
        if (u_if.edit_down  === 1'b1) down_cnt++;
        if (u_if.load_time  === 1'b1) lt_cnt++;
        if (u_if.load_alarm === 1'b1) la_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] d, input logic [1:0] f);
        chk({tag, ".disp"},  {6'd0, u_if.disp_sel},  {6'd0, d});
        chk({tag, ".field"}, {6'd0, u_if.field_sel}, {6'd0, f});
    endtask

    // One clock with the given one-cycle pulses; returns 1 unit after the rising edge.
    task automatic step(input logic s, input logic m, input logic u, input logic d, input logic t);
        @(negedge clk);
        u_if.set_pulse  = s;
        u_if.mode_pulse = m;
        u_if.up_pulse   = u;
        u_if.down_pulse = d;
        u_if.tick_1hz   = t;
        @(posedge clk);
        #1;
        u_if.set_pulse  = 1'b0;
        u_if.mode_pulse = 1'b0;
        u_if.up_pulse   = 1'b0;
        u_if.down_pulse = 1'b0;
        u_if.tick_1hz   = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        up_cnt = 0; down_cnt = 0; lt_cnt = 0; la_cnt = 0;
        u_if.set_pulse = 0; u_if.mode_pulse = 0; u_if.up_pulse = 0;
        u_if.down_pulse = 0; u_if.tick_1hz = 0; u_if.alarm_match = 0;
        reset = 1'b1;
        #23;
        // Reset values
        chk_sel("rst", 2'd0, 2'd0);
        chk("rst.alarm_en", {7'd0, u_if.alarm_en}, 8'd0);
        chk("rst.ringing",  {7'd0, u_if.ringing},  8'd0);
        chk("rst.load_time", {7'd0, u_if.load_time}, 8'd0);
        @(negedge clk); reset = 1'b0;

        // Time set with two UP presses in the hour field
        step(1, 0, 0, 0, 0); chk_sel("ts.hour", 2'd1, 2'd1);
        step(0, 0, 1, 0, 0); chk("ts.up1", {7'd0, u_if.edit_up}, 8'd1);
        step(0, 0, 1, 0, 0); chk("ts.up2", {7'd0, u_if.edit_up}, 8'd1);
        step(1, 0, 0, 0, 0); chk_sel("ts.min", 2'd1, 2'd2);
        step(1, 0, 0, 0, 0); chk_sel("ts.ampm", 2'd1, 2'd3);
        step(1, 0, 0, 0, 0); chk_sel("ts.idle", 2'd0, 2'd0);
        chk("ts.load_time", {7'd0, u_if.load_time}, 8'd1);
        step(0, 0, 0, 0, 0); chk("ts.load_time_off", {7'd0, u_if.load_time}, 8'd0);
        chk("ts.up_count", 8'(up_cnt), 8'd2);
        chk("ts.lt_count", 8'(lt_cnt), 8'd1);

        // Idle timeout after 30 ticks, no commit
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 29; i++) step(0, 0, 0, 0, 1);
        chk_sel("to.tick29", 2'd1, 2'd1);
        step(0, 0, 0, 0, 1); chk_sel("to.tick30", 2'd0, 2'd0);
        chk("to.lt_count", 8'(lt_cnt), 8'd1);

        // UP coinciding with tick 29 clears the counter
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 28; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1); chk("tu.edit_up", {7'd0, u_if.edit_up}, 8'd1);
        step(0, 0, 0, 0, 1); chk_sel("tu.tick30", 2'd1, 2'd1);
        step(0, 1, 0, 0, 0); chk_sel("tu.abort", 2'd0, 2'd0);
        chk("tu.lt_count", 8'(lt_cnt), 8'd1);
        chk("tu.alarm_en", {7'd0, u_if.alarm_en}, 8'd0);

        // Alarm set, then ring and stop with DOWN
        step(0, 1, 0, 0, 0); chk_sel("as.hour", 2'd2, 2'd1);
        step(1, 0, 0, 0, 0); chk_sel("as.min", 2'd2, 2'd2);
        step(1, 0, 0, 0, 0); chk_sel("as.ampm", 2'd2, 2'd3);
        step(1, 0, 0, 0, 0); chk_sel("as.idle", 2'd0, 2'd0);
        chk("as.load_alarm", {7'd0, u_if.load_alarm}, 8'd1);
        chk("as.alarm_en", {7'd0, u_if.alarm_en}, 8'd1);
        step(0, 0, 0, 0, 0); chk("as.la_count", 8'(la_cnt), 8'd1);
        u_if.alarm_match = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rg.ringing", {7'd0, u_if.ringing}, 8'd1);
        chk("rg.disp", {6'd0, u_if.disp_sel}, 8'd3);
        step(0, 0, 0, 1, 0);
        chk("rg.stop", {7'd0, u_if.ringing}, 8'd0);
        chk_sel("rg.idle", 2'd0, 2'd0);
        chk("rg.down_count", 8'(down_cnt), 8'd0);
        chk("rg.alarm_en", {7'd0, u_if.alarm_en}, 8'd1);
        u_if.alarm_match = 1'b0;
        step(0, 0, 0, 0, 0);

        // Ring for 60 ticks, no re-ring while match stays high
        u_if.alarm_match = 1'b1;
        step(0, 0, 0, 0, 0); chk("rt.ring", {7'd0, u_if.ringing}, 8'd1);
        for (int i = 1; i <= 59; i++) step(0, 0, 0, 0, 1);
        chk("rt.tick59", {7'd0, u_if.ringing}, 8'd1);
        step(0, 0, 0, 0, 1); chk("rt.tick60", {7'd0, u_if.ringing}, 8'd0);
        chk("rt.alarm_en", {7'd0, u_if.alarm_en}, 8'd1);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1);
        chk("rt.held", {7'd0, u_if.ringing}, 8'd0);
        u_if.alarm_match = 1'b0;
        step(0, 0, 0, 0, 0);
        u_if.alarm_match = 1'b1;
        step(0, 0, 0, 0, 0); chk("rt.rearm", {7'd0, u_if.ringing}, 8'd1);
        step(0, 0, 0, 1, 0); chk("rt.stop", {7'd0, u_if.ringing}, 8'd0);
        u_if.alarm_match = 1'b0;
        step(0, 0, 0, 0, 0);

        // Match edge during an edit session is dropped
        step(1, 0, 0, 0, 0);
        u_if.alarm_match = 1'b1;
        step(0, 0, 0, 0, 0); chk_sel("dr.edit", 2'd1, 2'd1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("dr.noring", {7'd0, u_if.ringing}, 8'd0);
        u_if.alarm_match = 1'b0;

        // SET+MODE together: MODE wins
        step(1, 1, 0, 0, 0); chk_sel("pr.mode_wins", 2'd2, 2'd1);
        step(0, 1, 0, 0, 0); chk("pr.la_count", 8'(la_cnt), 8'd1);

        // Reset in the middle of a time edit
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); chk_sel("rm.min", 2'd1, 2'd2);
        @(negedge clk); #2; reset = 1'b1; #1;
        chk_sel("rm.rst", 2'd0, 2'd0);
        chk("rm.alarm_en", {7'd0, u_if.alarm_en}, 8'd0);
        chk("rm.ringing", {7'd0, u_if.ringing}, 8'd0);
        @(negedge clk); reset = 1'b0;
        chk("rm.lt_count", 8'(lt_cnt), 8'd1);
        step(1, 0, 0, 0, 0); chk_sel("rm.first_edge", 2'd1, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
